fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 7 +
 rtl/fifo_rr_pick.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 69 ++++++
 tb/tb_fifo_wr_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type and default sizing for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int DEF_DATA_SIZE = 12;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_BURST_MAX = 8;
endpackage

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick: combinational round-robin pick, search starts at last+1 (mod NUM_REQ)
//   mask  : request mask (one bit per requester)
//   last  : index of the previous grantee
//   pick  : first set mask bit at or after last+1, wrapping
//   any   : at least one mask bit set
module fifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      pick,
  output logic               any
);
  logic [IW-1:0] idx;
  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (mask[idx]) pick = idx;
    end
  end
  assign any = |mask;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters
//   wclk, wrst      : clock, asynchronous active-low reset
//   cfg_enable      : per-requester arbitration enable (sampled only in IDLE)
//   req_valid/data  : per-requester word offer, word i at [i*DATA_SIZE +: DATA_SIZE]
//   req_ready       : word of requester i accepted this cycle
//   wFull           : FIFO full; gates winc
//   winc, wData     : FIFO write strobe and data
//   grant_id, busy  : current/last grantee, high while a burst is granted
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int IW = $clog2(NUM_REQ),
  parameter int BW = $clog2(BURST_MAX + 1)
) (
  input  logic                         wclk,
  input  logic                         wrst,
  input  logic [NUM_REQ-1:0]           cfg_enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wFull,
  output logic                         winc,
  output logic [DATA_SIZE-1:0]         wData,
  output logic [IW-1:0]                grant_id,
  output logic                         busy
);
  state_t state, state_nx;
  logic [IW-1:0] last_grant, pick;
  logic [BW-1:0] beat_cnt;
  logic any, gv, last_beat;
  fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .mask(req_valid & cfg_enable),
    .last(last_grant),
    .pick(pick),
    .any (any)
  );
  assign gv = req_valid[grant_id];
  assign last_beat = beat_cnt == BW'(BURST_MAX - 1);
  always_ff @(posedge wclk or negedge wrst)
    if (!wrst) state <= IDLE;
    else state <= state_nx;
  // A burst ends on its final accepted word or as soon as the grantee stops offering.
  always_comb
    state_nx = (state == IDLE) ? (any ? GRANT : IDLE)
             : ((!gv || (winc && last_beat)) ? IDLE : GRANT);
  always_comb begin
    busy = state == GRANT;
    winc = busy && gv && !wFull;
    req_ready = winc ? NUM_REQ'(1) << grant_id : '0;
    wData = req_data[int'(grant_id)*DATA_SIZE +: DATA_SIZE];
  end
  always_ff @(posedge wclk or negedge wrst)
    if (!wrst) begin
      grant_id <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (any) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end
    end else begin
      if (winc) beat_cnt <= beat_cnt + BW'(1);
      if (state_nx == IDLE) last_grant <= grant_id;
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench with a burst-level behavioural model checked every cycle
module tb_fifo_wr_arbiter;
  localparam int DW = 12, NR = 4, BM = 4;
  logic wclk = 0, wrst = 0;
  logic [NR-1:0] cfg_enable, req_valid, req_ready;
  logic [NR*DW-1:0] req_data;
  logic wFull, winc, busy;
  logic [DW-1:0] wData;
  logic [1:0] grant_id;
  int n_checks = 0, n_fail = 0, cyc = 0;
  bit m_active;
  int m_owner, m_words, m_last;
  int log_q[$];
  int exp_q[$];

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.DATA_SIZE(DW), .NUM_REQ(NR), .BURST_MAX(BM)) dut (
    .wclk(wclk), .wrst(wrst), .cfg_enable(cfg_enable), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .wFull(wFull), .winc(winc),
    .wData(wData), .grant_id(grant_id), .busy(busy)
  );

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_log(input string name, input int exp[$]);
    check($sformatf("%s_len", name), log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), log_q[i], exp[i]);
  endtask

  function automatic int rr_model(input logic [NR-1:0] m, input int last);
    for (int k = 1; k <= NR; k++)
      if (m[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(i * 256 + (cyc & 255));
  endtask

  task automatic do_reset();
    wrst = 0;
    tick();
    tick();
    wrst = 1;
    log_q.delete();
  endtask

  // Model: a burst owns the port until BM words are written or its owner stops offering;
  // after every burst one cycle passes before a new owner is picked.
  initial forever begin
    @(negedge wclk);
    if (!wrst) begin
      m_active = 0; m_owner = 0; m_last = NR - 1; m_words = 0;
      check("rst_winc", winc, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", req_ready, 0);
      check("rst_gid", grant_id, 0);
      log_q.push_back(-1);
    end else begin
      bit wr;
      int pick;
      wr = m_active && req_valid[m_owner] && !wFull;
      check("busy", busy, m_active);
      check("grant_id", grant_id, m_owner);
      check("winc", winc, wr);
      check("req_ready", req_ready, wr ? (1 << m_owner) : 0);
      if (m_active) check("wData", wData, req_data[m_owner*DW +: DW]);
      log_q.push_back(winc ? int'(grant_id) : -1);
      if (!m_active) begin
        pick = rr_model(req_valid & cfg_enable, m_last);
        if (pick >= 0) begin
          m_active = 1; m_owner = pick; m_words = 0;
        end
      end else begin
        if (wr) m_words++;
        if (!req_valid[m_owner] || m_words == BM) begin
          m_active = 0; m_last = m_owner;
        end
      end
    end
  end

  initial begin
    wFull = 0;
    cfg_enable = '1;
    req_valid = '1;
    req_data = '0;
    tick(); tick(); tick();
    check("rst_hold_winc", winc, 0);
    check("rst_hold_busy", busy, 0);
    wrst = 1;
    log_q.delete();
    repeat (25) tick();
    exp_q = '{-1, 0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 2, 2, 2, 2, -1, 3, 3, 3, 3, -1, 0, 0, 0, 0};
    check_log("fair", exp_q);
    req_valid = 4'b0100;
    do_reset();
    tick(); tick(); tick();
    req_valid = '0;
    tick(); tick(); tick();
    exp_q = '{-1, 2, 2, -1, -1, -1};
    check_log("early", exp_q);
    check("early_idle", busy, 0);
    req_valid = '1;
    log_q.delete();
    tick(); tick();
    exp_q = '{-1, 3};
    check_log("after_early", exp_q);
    req_valid = 4'b0001;
    do_reset();
    tick(); tick();
    wFull = 1;
    repeat (5) tick();
    wFull = 0;
    repeat (5) tick();
    exp_q = '{-1, 0, -1, -1, -1, -1, -1, 0, 0, 0, -1, 0};
    check_log("stall", exp_q);
    cfg_enable = 4'b1010;
    req_valid = '1;
    do_reset();
    repeat (15) tick();
    exp_q = '{-1, 1, 1, 1, 1, -1, 3, 3, 3, 3, -1, 1, 1, 1, 1};
    check_log("mask", exp_q);
    cfg_enable = '1;
    req_valid = 4'b0010;
    do_reset();
    tick(); tick(); tick();
    check("pre_rst_winc", winc, 1);
    check("pre_rst_gid", grant_id, 1);
    wrst = 0;
    #1;
    check("midrst_winc", winc, 0);
    check("midrst_busy", busy, 0);
    req_valid = '1;
    tick();
    wrst = 1;
    log_q.delete();
    tick(); tick();
    exp_q = '{-1, 0};
    check_log("midrst", exp_q);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
